// File: rtl/fcmp_pkg.sv
// Shared types and constants for the fcmp_arbiter slice (13-bit FloPoCo operands).
package fcmp_pkg;

    localparam int unsigned FP_W     = 13;
    localparam int unsigned EXC_HI   = 12;
    localparam int unsigned SIGN_BIT = 10;
    localparam int unsigned ID_MAX_W = 3;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_e;

    typedef struct packed {
        logic [FP_W-1:0]     x;
        logic [FP_W-1:0]     y;
        logic [ID_MAX_W-1:0] id;
    } s1_payload_t;

endpackage

// File: rtl/fcmplt.sv
// Combinational FloPoCo less-than comparator; unordered_c flags a NaN on either side.
module fcmplt
    import fcmp_pkg::*;
#(
    parameter int ID = 1
) (
    input  logic [FP_W-1:0] x,
    input  logic [FP_W-1:0] y,
    output logic            lt_c,
    output logic            unordered_c
);

    if (ID < 0) begin : g_bad_id
        $error("fcmplt: ID must be non-negative");
    end

    // Monotonic magnitude key: zero < normals (by exp/frac) < inf; signed zeros collapse to 0.
    function automatic logic [EXC_HI-1:0] mag_key(input logic [FP_W-1:0] v);
        logic [EXC_HI-1:0] key;
        case (exc_e'(v[EXC_HI -: 2]))
            EXC_ZERO:   key = '0;
            EXC_NORMAL: key = {2'b01, v[SIGN_BIT-1:0]};
            EXC_INF:    key = {2'b10, (SIGN_BIT)'(0)};
            EXC_NAN:    key = {2'b11, v[SIGN_BIT-1:0]};
        endcase
        return key;
    endfunction

    logic [EXC_HI-1:0] kx_c;
    logic [EXC_HI-1:0] ky_c;
    logic              x_neg_c;
    logic              y_neg_c;

    always_comb begin
        kx_c        = mag_key(x);
        ky_c        = mag_key(y);
        x_neg_c     = x[SIGN_BIT] && (kx_c != '0);
        y_neg_c     = y[SIGN_BIT] && (ky_c != '0);
        unordered_c = (exc_e'(x[EXC_HI -: 2]) == EXC_NAN) || (exc_e'(y[EXC_HI -: 2]) == EXC_NAN);
        if (x_neg_c != y_neg_c) begin
            lt_c = x_neg_c;
        end else if (x_neg_c) begin
            lt_c = kx_c > ky_c;
        end else begin
            lt_c = kx_c < ky_c;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin search: first set req bit at or after rr (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic found_c;
    int   j_c;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found_c = 1'b0;
        j_c     = 0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            j_c = (int'(rr) + k) % int'(N_REQ);
            if (!found_c && req[j_c]) begin
                found_c  = 1'b1;
                gnt[j_c] = 1'b1;
                gnt_idx  = IDX_W'(j_c);
            end
        end
    end

endmodule

// File: rtl/fcmp_arbiter.sv
// N_REQ-way round-robin front end sharing one fcmplt through a two-stage pipeline.
// Optional FCMP_ARB_UNORDERED_EN adds resp_unordered and sticky unordered_seen outputs.
module fcmp_arbiter
    import fcmp_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int          ID    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*FP_W-1:0]    req_x,
    input  logic [N_REQ*FP_W-1:0]    req_y,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    output logic                     resp_lt
`ifdef FCMP_ARB_UNORDERED_EN
    ,
    output logic                     resp_unordered,
    output logic                     unordered_seen
`endif
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0] gnt_c;
    logic [IDX_W-1:0] gnt_idx_c;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic             s1_valid_q, s1_valid_d;
    s1_payload_t      s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [IDX_W-1:0] s2_id_q, s2_id_d;
    logic             s2_lt_q, s2_lt_d;
    logic             s1_adv_c, s2_adv_c, fire_c;
    logic [FP_W-1:0]  gx_c, gy_c;
    logic             lt_c, unord_c;
`ifdef FCMP_ARB_UNORDERED_EN
    logic             s2_unord_q, s2_unord_d;
    logic             seen_q, seen_d;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (req_valid),
        .rr      (rr_q),
        .gnt     (gnt_c),
        .gnt_idx (gnt_idx_c)
    );

    fcmplt #(.ID(ID)) u_cmp (
        .x           (s1_q.x),
        .y           (s1_q.y),
        .lt_c        (lt_c),
        .unordered_c (unord_c)
    );

    always_comb begin
        s2_adv_c  = !s2_valid_q || resp_ready;
        s1_adv_c  = !s1_valid_q || s2_adv_c;
        req_ready = (s1_adv_c && !rst) ? gnt_c : '0;
        fire_c    = |(req_valid & req_ready);

        // gnt_c is one-hot, so the OR-mux selects exactly one operand pair.
        gx_c = '0;
        gy_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (gnt_c[i]) begin
                gx_c = req_x[i*FP_W +: FP_W];
                gy_c = req_y[i*FP_W +: FP_W];
            end
        end

        rr_d = rr_q;
        if (fire_c) begin
            rr_d = (gnt_idx_c == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
        end

        s1_valid_d = s1_adv_c ? fire_c : s1_valid_q;
        s1_d       = s1_q;
        if (fire_c) begin
            s1_d.x  = gx_c;
            s1_d.y  = gy_c;
            s1_d.id = ID_MAX_W'(gnt_idx_c);
        end

        s2_valid_d = s2_adv_c ? s1_valid_q : s2_valid_q;
        s2_id_d    = s2_id_q;
        s2_lt_d    = s2_lt_q;
`ifdef FCMP_ARB_UNORDERED_EN
        s2_unord_d = s2_unord_q;
        seen_d     = seen_q | (s2_valid_q & resp_ready & s2_unord_q);
`endif
        if (s2_adv_c && s1_valid_q) begin
            s2_id_d = IDX_W'(s1_q.id);
            s2_lt_d = lt_c & ~unord_c;
`ifdef FCMP_ARB_UNORDERED_EN
            s2_unord_d = unord_c;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= '0;
            s2_lt_q    <= 1'b0;
`ifdef FCMP_ARB_UNORDERED_EN
            s2_unord_q <= 1'b0;
            seen_q     <= 1'b0;
`endif
        end else begin
            rr_q       <= rr_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_id_q    <= s2_id_d;
            s2_lt_q    <= s2_lt_d;
`ifdef FCMP_ARB_UNORDERED_EN
            s2_unord_q <= s2_unord_d;
            seen_q     <= seen_d;
`endif
        end
    end

    assign resp_valid = s2_valid_q;
    assign resp_id    = s2_id_q;
    assign resp_lt    = s2_lt_q;
`ifdef FCMP_ARB_UNORDERED_EN
    assign resp_unordered = s2_unord_q;
    assign unordered_seen = seen_q;
`endif

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed self-checking bench for fcmp_arbiter with N_REQ=4.
module tb_fcmp_arbiter;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*13-1:0] req_x;
    logic [N*13-1:0] req_y;
    logic [N-1:0]  req_ready;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_id;
    logic          resp_lt;
`ifdef FCMP_ARB_UNORDERED_EN
    logic          resp_unordered;
    logic          unordered_seen;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Directed compare vectors: X, Y, expected X<Y.
    logic [12:0] cx [9] = '{13'h09E0, 13'h0A00, 13'h0DE0, 13'h0000, 13'h0E00,
                            13'h1000, 13'h0400, 13'h0A00, 13'h1400};
    logic [12:0] cy [9] = '{13'h0A00, 13'h09E0, 13'h0000, 13'h0000, 13'h0DE0,
                            13'h0A00, 13'h0000, 13'h1000, 13'h0DE0};
    logic        cl [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // Full-load operands per requester; expected lt for ids 0..3 is 1,0,1,0.
    logic [3:0] lt_tab = 4'b0101;

    fcmp_arbiter #(.N_REQ(N), .ID(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_lt    (resp_lt)
`ifdef FCMP_ARB_UNORDERED_EN
        ,
        .resp_unordered (resp_unordered),
        .unordered_seen (unordered_seen)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_load();
        req_x = {13'h0000, 13'h0DE0, 13'h0A00, 13'h09E0};
        req_y = {13'h0000, 13'h0000, 13'h09E0, 13'h0A00};
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        set_load();
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_rdy: got %b want 0000", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_rv: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (resp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", resp_id); else n_pass++;
        n_checks++; if (resp_lt !== 1'b0) $display("FAIL reset_lt: got %b want 0", resp_lt); else n_pass++;
`ifdef FCMP_ARB_UNORDERED_EN
        n_checks++; if (resp_unordered !== 1'b0) $display("FAIL reset_unord: got %b want 0", resp_unordered); else n_pass++;
        n_checks++; if (unordered_seen !== 1'b0) $display("FAIL reset_seen: got %b want 0", unordered_seen); else n_pass++;
`endif
        req_valid = '0;
        rst = 1'b0;
    endtask

    task automatic test_compare();
        for (int i = 0; i < 9; i++) begin
            int idx;
            logic [3:0] oh;
            idx = i % N;
            oh  = 4'(1 << idx);
            req_x = '0;
            req_y = '0;
            req_x[idx*13 +: 13] = cx[i];
            req_y[idx*13 +: 13] = cy[i];
            req_valid = oh;
            #1;
            n_checks++; if (req_ready !== oh) $display("FAIL cmp%0d_rdy: got %b want %b", i, req_ready, oh); else n_pass++;
            @(posedge clk); @(negedge clk);
            req_valid = '0;
            n_checks++; if (resp_valid !== 1'b0) $display("FAIL cmp%0d_early: got %b want 0", i, resp_valid); else n_pass++;
            @(posedge clk); @(negedge clk);
            n_checks++; if (resp_valid !== 1'b1) $display("FAIL cmp%0d_rv: got %b want 1", i, resp_valid); else n_pass++;
            n_checks++; if (resp_id !== 2'(idx)) $display("FAIL cmp%0d_id: got %0d want %0d", i, resp_id, idx); else n_pass++;
            n_checks++; if (resp_lt !== cl[i]) $display("FAIL cmp%0d_lt: got %b want %b", i, resp_lt, cl[i]); else n_pass++;
`ifdef FCMP_ARB_UNORDERED_EN
            n_checks++; if (resp_unordered !== 1'b0) $display("FAIL cmp%0d_unord: got %b want 0", i, resp_unordered); else n_pass++;
`endif
            @(posedge clk); @(negedge clk);
            n_checks++; if (resp_valid !== 1'b0) $display("FAIL cmp%0d_dup: got %b want 0", i, resp_valid); else n_pass++;
        end
`ifdef FCMP_ARB_UNORDERED_EN
        n_checks++; if (unordered_seen !== 1'b0) $display("FAIL cmp_seen: got %b want 0", unordered_seen); else n_pass++;
`endif
    endtask

    task automatic test_nan();
        logic [12:0] nx [2] = '{13'h1800, 13'h09E0};
        logic [12:0] ny [2] = '{13'h09E0, 13'h1800};
        for (int i = 0; i < 2; i++) begin
            req_x = '0;
            req_y = '0;
            req_x[13 +: 13] = nx[i];
            req_y[13 +: 13] = ny[i];
            req_valid = 4'b0010;
            @(posedge clk); @(negedge clk);
            req_valid = '0;
            @(posedge clk); @(negedge clk);
            n_checks++; if (resp_valid !== 1'b1) $display("FAIL nan%0d_rv: got %b want 1", i, resp_valid); else n_pass++;
            n_checks++; if (resp_lt !== 1'b0) $display("FAIL nan%0d_lt: got %b want 0", i, resp_lt); else n_pass++;
`ifdef FCMP_ARB_UNORDERED_EN
            n_checks++; if (resp_unordered !== 1'b1) $display("FAIL nan%0d_unord: got %b want 1", i, resp_unordered); else n_pass++;
`endif
            @(posedge clk); @(negedge clk);
`ifdef FCMP_ARB_UNORDERED_EN
            n_checks++; if (unordered_seen !== 1'b1) $display("FAIL nan%0d_seen: got %b want 1", i, unordered_seen); else n_pass++;
`endif
        end
        // An ordered result afterwards must not clear the sticky flag.
        req_x = '0;
        req_y = '0;
        req_x[12:0] = 13'h09E0;
        req_y[12:0] = 13'h0A00;
        req_valid = 4'b0001;
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        n_checks++; if (resp_lt !== 1'b1) $display("FAIL nan_after_lt: got %b want 1", resp_lt); else n_pass++;
        @(posedge clk); @(negedge clk);
`ifdef FCMP_ARB_UNORDERED_EN
        n_checks++; if (unordered_seen !== 1'b1) $display("FAIL nan_sticky: got %b want 1", unordered_seen); else n_pass++;
        do_reset();
        n_checks++; if (unordered_seen !== 1'b0) $display("FAIL nan_seen_rst: got %b want 0", unordered_seen); else n_pass++;
`endif
    endtask

    task automatic test_fairness();
        do_reset();
        set_load();
        resp_ready = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            logic [3:0] exp_rdy;
            int exp_id;
            exp_rdy = 4'(1 << (k % N));
            exp_id  = (k - 2) % N;
            #1;
            n_checks++; if (req_ready !== exp_rdy) $display("FAIL fair%0d_rdy: got %b want %b", k, req_ready, exp_rdy); else n_pass++;
            if (k < 2) begin
                n_checks++; if (resp_valid !== 1'b0) $display("FAIL fair%0d_rv: got %b want 0", k, resp_valid); else n_pass++;
            end else begin
                n_checks++; if (resp_valid !== 1'b1) $display("FAIL fair%0d_rv: got %b want 1", k, resp_valid); else n_pass++;
                n_checks++; if (resp_id !== 2'(exp_id)) $display("FAIL fair%0d_id: got %0d want %0d", k, resp_id, exp_id); else n_pass++;
                n_checks++; if (resp_lt !== lt_tab[exp_id]) $display("FAIL fair%0d_lt: got %b want %b", k, resp_lt, lt_tab[exp_id]); else n_pass++;
            end
            @(posedge clk); @(negedge clk);
        end
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        set_load();
        req_valid = 4'hF;
        for (int k = 0; k < 10; k++) begin
            logic [3:0] exp_rdy;
            int exp_id;
            resp_ready = (k >= 5);
            #1;
            if (k == 0)      exp_rdy = 4'b0001;
            else if (k == 1) exp_rdy = 4'b0010;
            else if (k < 5)  exp_rdy = 4'b0000;
            else             exp_rdy = 4'(1 << ((k - 3) % N));
            exp_id = (k < 5) ? 0 : (k - 5) % N;
            n_checks++; if (req_ready !== exp_rdy) $display("FAIL bp%0d_rdy: got %b want %b", k, req_ready, exp_rdy); else n_pass++;
            if (k < 2) begin
                n_checks++; if (resp_valid !== 1'b0) $display("FAIL bp%0d_rv: got %b want 0", k, resp_valid); else n_pass++;
            end else begin
                n_checks++; if (resp_valid !== 1'b1) $display("FAIL bp%0d_rv: got %b want 1", k, resp_valid); else n_pass++;
                n_checks++; if (resp_id !== 2'(exp_id)) $display("FAIL bp%0d_id: got %0d want %0d", k, resp_id, exp_id); else n_pass++;
                n_checks++; if (resp_lt !== lt_tab[exp_id]) $display("FAIL bp%0d_lt: got %b want %b", k, resp_lt, lt_tab[exp_id]); else n_pass++;
            end
            @(posedge clk); @(negedge clk);
        end
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_load();
        resp_ready = 1'b0;
        req_valid = 4'hF;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL mid_full_rv: got %b want 1", resp_valid); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL mid_rst_rdy: got %b want 0000", req_ready); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL mid_rv: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (resp_id !== 2'd0) $display("FAIL mid_id: got %0d want 0", resp_id); else n_pass++;
        n_checks++; if (resp_lt !== 1'b0) $display("FAIL mid_lt: got %b want 0", resp_lt); else n_pass++;
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_gnt: got %b want 0001", req_ready); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL mid_aborted: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (req_ready !== 4'b0010) $display("FAIL mid_second_gnt: got %b want 0010", req_ready); else n_pass++;
        @(posedge clk); @(negedge clk);
        n_checks++; if (resp_valid !== 1'b1) $display("FAIL mid_resume_rv: got %b want 1", resp_valid); else n_pass++;
        n_checks++; if (resp_id !== 2'd0) $display("FAIL mid_resume_id: got %0d want 0", resp_id); else n_pass++;
        req_valid = '0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b1;
        test_reset();
        test_compare();
        test_nan();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
